// File: rtl/vc_test_rand_delay.sv
// Single-entry val/rdy buffer that holds each message for an LFSR-chosen delay before sending.
// Optional VC_TEST_RAND_DELAY_STATS_EN adds message and stall-cycle counters.
module vc_test_rand_delay #(
  parameter int unsigned p_msg_sz    = 1,
  parameter int unsigned p_max_delay = 0,
  parameter logic [15:0] p_seed      = 16'hB1C5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [p_msg_sz-1:0] out_msg
`ifdef VC_TEST_RAND_DELAY_STATS_EN
  ,
  output logic [31:0]         num_msgs,
  output logic [31:0]         num_stall_cycles
`endif
);

  localparam int unsigned c_cnt_sz = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam logic [15:0] c_mod    = 16'(p_max_delay + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SEND} state_t;

  state_t                state, state_next;
  logic [p_msg_sz-1:0]   msg_reg;
  logic [c_cnt_sz-1:0]   count;
  logic [15:0]           lfsr;
  logic [c_cnt_sz-1:0]   rd;
  logic                  lfsr_fb;
  logic                  in_fire, out_fire;

  // Delay comes from the LFSR value before it advances on this fire.
  assign rd       = c_cnt_sz'(lfsr % c_mod);
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;
  assign out_msg  = msg_reg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (in_fire) state_next = (rd == '0) ? SEND : DELAY;
      DELAY: if (count == '0) state_next = SEND;
      SEND: begin
        if (out_fire) begin
          if (in_fire) state_next = (rd == '0) ? SEND : DELAY;
          else         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_rdy sees out_rdy combinationally in SEND so a drain and refill share a cycle.
  always_comb begin
    in_rdy  = (state == IDLE) || ((state == SEND) && out_rdy);
    out_val = (state == SEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_reg <= '0;
      count   <= '0;
      lfsr    <= p_seed;
    end else if (in_fire) begin
      msg_reg <= in_msg;
      lfsr    <= {lfsr[14:0], lfsr_fb};
      if (rd != '0) count <= rd - c_cnt_sz'(1);
    end else if ((state == DELAY) && (count != '0)) begin
      count <= count - c_cnt_sz'(1);
    end
  end

`ifdef VC_TEST_RAND_DELAY_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      num_msgs         <= '0;
      num_stall_cycles <= '0;
    end else begin
      if (out_fire) num_msgs <= num_msgs + 32'd1;
      if ((state == DELAY) || ((state == SEND) && !out_rdy))
        num_stall_cycles <= num_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_test_rand_delay.sv
// Bench for vc_test_rand_delay: zero-delay streaming, random delays with an LFSR
// model, backpressure, simultaneous fire and reset in the middle of a delay.
module tb_vc_test_rand_delay;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // a: max delay 0, b: max delay 7, c: max delay 15
  logic       a_in_val = 1'b0, a_out_rdy = 1'b0, a_in_rdy, a_out_val;
  logic [7:0] a_in_msg = '0, a_out_msg;
  logic       b_in_val = 1'b0, b_out_rdy = 1'b0, b_in_rdy, b_out_val;
  logic [7:0] b_in_msg = '0, b_out_msg;
  logic       c_in_val = 1'b0, c_out_rdy = 1'b0, c_in_rdy, c_out_val;
  logic [7:0] c_in_msg = '0, c_out_msg;
`ifdef VC_TEST_RAND_DELAY_STATS_EN
  logic [31:0] a_nm, a_ns, b_nm, b_ns, c_nm, c_ns;
`endif

  vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(0), .p_seed(16'hB1C5)) dut_a (
    .clk(clk), .reset(reset), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg)
`ifdef VC_TEST_RAND_DELAY_STATS_EN
    , .num_msgs(a_nm), .num_stall_cycles(a_ns)
`endif
  );

  vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(7), .p_seed(16'hB1C5)) dut_b (
    .clk(clk), .reset(reset), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg)
`ifdef VC_TEST_RAND_DELAY_STATS_EN
    , .num_msgs(b_nm), .num_stall_cycles(b_ns)
`endif
  );

  vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(15), .p_seed(16'hB1C5)) dut_c (
    .clk(clk), .reset(reset), .in_val(c_in_val), .in_rdy(c_in_rdy), .in_msg(c_in_msg),
    .out_val(c_out_val), .out_rdy(c_out_rdy), .out_msg(c_out_msg)
`ifdef VC_TEST_RAND_DELAY_STATS_EN
    , .num_msgs(c_nm), .num_stall_cycles(c_ns)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Scoreboard for b: predicts state and delay from its own LFSR model.
  logic [7:0]  b_q[$];
  logic [15:0] b_lfsr = 16'hB1C5;
  bit          b_pend = 1'b0;
  int          b_due  = 0;

  initial begin
    bit snd;
    int rd;
    forever begin
      @(negedge clk);
      if (reset) begin
        b_q.delete();
        b_pend = 1'b0;
        b_lfsr = 16'hB1C5;
      end else begin
        snd = b_pend && (cyc >= b_due);
        chk("b_out_val", b_out_val, snd);
        chk("b_in_rdy", b_in_rdy, !b_pend || (snd && b_out_rdy));
        if (snd && b_q.size() > 0) chk("b_out_msg", b_out_msg, b_q[0]);
        if (b_out_val && b_out_rdy) begin
          chk("b_pop_depth", b_q.size(), 1);
          if (b_q.size() > 0) void'(b_q.pop_front());
          b_pend = 1'b0;
        end
        if (b_in_val && b_in_rdy) begin
          rd = int'(b_lfsr % 16'd8);
          b_q.push_back(b_in_msg);
          b_pend = 1'b1;
          b_due  = cyc + 1 + rd;
          b_lfsr = lfsr_next(b_lfsr);
        end
      end
    end
  end

  int tr1[$], tr2[$];

  task automatic run_b(input int n, input logic [7:0] base, input bit second);
    int idx = 0, fires = 0, t0 = cyc, budget = n * 20;
    while (fires < n && budget > 0) begin
      b_in_val  = (idx < n);
      b_in_msg  = 8'(base + idx);
      b_out_rdy = ((cyc - t0) % 3) != 2;
      #1;
      if (b_in_val && b_in_rdy) idx++;
      if (b_out_val && b_out_rdy) begin
        fires++;
        if (second) tr2.push_back(cyc - t0);
        else        tr1.push_back(cyc - t0);
      end
      tick();
      budget--;
    end
    b_in_val  = 1'b0;
    b_out_rdy = 1'b0;
    chk("b_fires", fires, n);
  endtask

  initial begin
    logic [7:0] a_q[$];
    logic [7:0] m;
    int lat, d_exp;
    bit f;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state, then idle
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rst_out_val", a_out_val, 1'b0);
      chk("rst_in_rdy", a_in_rdy, 1'b1);
      chk("rst_out_msg", a_out_msg, 8'h00);
      chk("rst_c_in_rdy", c_in_rdy, 1'b1);
      tick();
    end

    // zero delay streaming 01..04
    a_out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_val = (i < 4);
      a_in_msg = 8'(i + 1);
      #1;
      chk("a_stream_in_rdy", a_in_rdy, 1'b1);
      if (a_q.size() > 0) begin
        m = a_q.pop_front();
        chk("a_stream_val", a_out_val, 1'b1);
        chk("a_stream_msg", a_out_msg, m);
      end else if (i > 0) begin
        chk("a_stream_drained", a_out_val, 1'b0);
      end
      if (a_in_val && a_in_rdy) a_q.push_back(a_in_msg);
      tick();
    end

    // simultaneous fire: 8'h11 held, 8'h22 accepted as 8'h11 leaves
    a_out_rdy = 1'b0; a_in_val = 1'b1; a_in_msg = 8'h11;
    #1 chk("a_sim_accept", a_in_rdy, 1'b1);
    tick();
    a_in_val = 1'b0; a_in_msg = 8'h5A;
    #1;
    chk("a_sim_hold_val", a_out_val, 1'b1);
    chk("a_sim_hold_msg", a_out_msg, 8'h11);
    chk("a_sim_hold_rdy", a_in_rdy, 1'b0);
    tick();
    a_out_rdy = 1'b1; a_in_val = 1'b1; a_in_msg = 8'h22;
    #1;
    chk("a_sim_rdy", a_in_rdy, 1'b1);
    chk("a_sim_old_msg", a_out_msg, 8'h11);
    tick();
    a_in_val = 1'b0;
    #1;
    chk("a_sim_new_val", a_out_val, 1'b1);
    chk("a_sim_new_msg", a_out_msg, 8'h22);
    tick();
    #1;
    chk("a_sim_idle_val", a_out_val, 1'b0);
    chk("a_sim_idle_rdy", a_in_rdy, 1'b1);
    a_out_rdy = 1'b0;

    // random delays, replayed after reset for an identical trace
    run_b(20, 8'h30, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_b(20, 8'h30, 1'b1);
    chk("b_trace_len", tr2.size(), tr1.size());
    for (int i = 0; i < tr1.size() && i < tr2.size(); i++) chk("b_trace", tr2[i], tr1[i]);

    // downstream backpressure on 8'hAA
    b_out_rdy = 1'b0; b_in_val = 1'b1; b_in_msg = 8'hAA;
    f = 1'b0;
    for (int k = 0; k < 20 && !f; k++) begin
      #1 f = b_in_rdy;
      tick();
    end
    chk("b_bp_accept", f, 1'b1);
    b_in_val = 1'b0; b_in_msg = 8'h00;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (b_out_val) break;
      tick();
    end
    chk("b_bp_rise", b_out_val, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("b_bp_val", b_out_val, 1'b1);
      chk("b_bp_msg", b_out_msg, 8'hAA);
      chk("b_bp_in_rdy", b_in_rdy, 1'b0);
      tick();
      #1;
    end
    b_out_rdy = 1'b1;
    #1 chk("b_bp_release_rdy", b_in_rdy, 1'b1);
    tick();
    #1;
    chk("b_bp_idle_val", b_out_val, 1'b0);
    chk("b_bp_idle_rdy", b_in_rdy, 1'b1);
    b_out_rdy = 1'b0;

    // reset while c is in DELAY; first post-reset delay matches a fresh run
    d_exp = int'(16'hB1C5 % 16'd16);
    c_out_rdy = 1'b1; c_in_val = 1'b1; c_in_msg = 8'h77;
    #1 chk("c_accept", c_in_rdy, 1'b1);
    tick();
    c_in_val = 1'b0;
    #1;
    chk("c_delay_val", c_out_val, 1'b0);
    chk("c_delay_rdy", c_in_rdy, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("c_rst_val", c_out_val, 1'b0);
    chk("c_rst_rdy", c_in_rdy, 1'b1);
    chk("c_rst_msg", c_out_msg, 8'h00);
`ifdef VC_TEST_RAND_DELAY_STATS_EN
    chk("c_rst_num_msgs", c_nm, 32'd0);
    chk("c_rst_num_stall", c_ns, 32'd0);
`endif
    c_in_val = 1'b1; c_in_msg = 8'h88;
    tick();
    c_in_val = 1'b0;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (c_out_val) break;
      chk("c_no_stale_msg", c_out_msg, 8'h88);
      tick();
      lat++;
    end
    chk("c_first_delay", lat, 1 + d_exp);
    chk("c_post_msg", c_out_msg, 8'h88);
    tick();
    #1 chk("c_post_idle", c_out_val, 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
